// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the priority-encoder request queue.
package prio_enc_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int MAX_N      = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Out-of-range indices yield an all-zero mask rather than wrapping.
  function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    if (idx >= 0 && idx < n && idx < MAX_N) r[idx] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/prio_find.sv
// Find-first-set over N bits, searching upward from start and wrapping at N.
module prio_find #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  int p;

  // Walk the offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    found = |vec;
    idx   = '0;
    p     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      p = int'(start) + k;
      if (p >= N) p = p - N;
      if (vec[p]) idx = W'(p);
    end
  end
endmodule

// File: rtl/prio_enc_queue.sv
// Captures N request lines into a pending set and issues one index per slot on a
// valid/ready port, using fixed-priority or round-robin selection.
module prio_enc_queue
  import prio_enc_pkg::*;
#(
  parameter  int N    = 4,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend,
  output logic         overrun
);
  logic [N-1:0]     pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_idx_q, out_idx_d;
  logic             overrun_q, overrun_d;
  logic [W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [W-1:0]     start, sel;
  logic             found, slot;
  logic [MAX_N-1:0] oh;
  logic [N-1:0]     grant_mask;

  assign start = (MODE == MODE_RR) ? rr_ptr_q : '0;

  prio_find #(.N(N), .W(W)) u_find (
    .vec   (pend_q),
    .start (start),
    .found (found),
    .idx   (sel)
  );

  always_comb begin
    slot       = en & found & (~out_valid_q | out_ready);
    oh         = onehot(int'(sel), N);
    grant_mask = slot ? oh[N-1:0] : '0;
    // A req on the bit granted this cycle survives the clear as a fresh request.
    pend_d      = (pend_q & ~grant_mask) | (en ? req : '0);
    overrun_d   = en & (|(req & pend_q & ~grant_mask));
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (slot) begin
      out_valid_d = 1'b1;
      out_idx_d   = sel;
      rr_ptr_d    = (sel == W'(N - 1)) ? '0 : sel + W'(1);
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      overrun_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      overrun_q   <= overrun_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pend      = pend_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_prio_enc_queue.sv
// Drives four configurations (N=4/8, fixed/round-robin) from shared stimulus and
// checks each against a set-based reference model through a per-instance scoreboard.
module tb_prio_enc_queue;
  typedef struct {
    bit       v;
    int       idx;
    bit [7:0] pend;
    bit       ovr;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ready;
  logic [7:0] req;
  int         n_vec  = 0;
  int         n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int NN = (g < 2) ? 4 : 8;
    localparam int MM = g % 2;
    localparam int WW = (NN == 4) ? 2 : 3;

    logic          out_valid;
    logic [WW-1:0] out_idx;
    logic [NN-1:0] pend;
    logic          overrun;
    int            vecs;
    int            errs;
    exp_t          q[$];

    bit [7:0] mp;
    bit       mv;
    int       midx;
    int       mptr;
    bit       mo;

    prio_enc_queue #(.N(NN), .MODE(MM)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req[NN-1:0]),
      .out_valid (out_valid),
      .out_ready (ready),
      .out_idx   (out_idx),
      .pend      (pend),
      .overrun   (overrun)
    );

    // Predicts the state the DUT shows after the coming rising edge.
    task automatic model_step();
      exp_t     e;
      int       gi;
      bit       slot;
      bit [7:0] np;
      bit       ov;
      if (rst) begin
        mp = '0; mv = 0; midx = 0; mptr = 0; mo = 0;
      end else begin
        gi   = -1;
        slot = en && (mp != 0) && (!mv || ready);
        if (slot)
          for (int i = 0; i < NN; i++) begin
            int p;
            p = ((MM == 1 ? mptr : 0) + i) % NN;
            if (gi < 0 && mp[p]) gi = p;
          end
        ov = 0;
        np = '0;
        for (int b = 0; b < NN; b++) begin
          if (en && req[b] && mp[b] && b != gi) ov = 1;
          np[b] = (mp[b] && b != gi) || (en && req[b]);
        end
        mp = np;
        mo = ov;
        if (slot) begin
          mv = 1; midx = gi; mptr = (gi + 1) % NN;
        end else if (mv && ready) begin
          mv = 0;
        end
      end
      e.v = mv; e.idx = midx; e.pend = mp; e.ovr = mo;
      q.push_back(e);
    endtask

    task automatic check(input exp_t e);
      bit [7:0] ap;
      ap = 8'(pend);
      vecs++;
      n_vec++;
      if (out_valid !== e.v || int'(out_idx) != e.idx || ap != e.pend || overrun !== e.ovr) begin
        errs++;
        n_fail++;
        $display("FAIL cfg%0d(N=%0d,MODE=%0d) t=%0t: got valid=%0b idx=%0d pend=%h ovr=%0b, want valid=%0b idx=%0d pend=%h ovr=%0b",
                 g, NN, MM, $time, out_valid, out_idx, ap, overrun, e.v, e.idx, e.pend, e.ovr);
      end
    endtask

    initial begin
      mp = '0; mv = 0; midx = 0; mptr = 0; mo = 0;
      forever begin
        @(negedge clk);
        model_step();
      end
    end

    // Pops one prediction per clock edge; an async reset edge with nothing queued
    // must show the cleared state immediately.
    initial begin
      exp_t e;
      vecs = 0;
      errs = 0;
      forever begin
        @(posedge clk or posedge rst);
        #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          check(e);
        end else if (rst) begin
          e.v = 0; e.idx = 0; e.pend = '0; e.ovr = 0;
          check(e);
        end
      end
    end
  end

  task automatic step(input bit r, input logic [7:0] rq, input bit e, input bit rd, input int n);
    rst   = r;
    req   = rq;
    en    = e;
    ready = rd;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    logic [7:0] rq;
    rst = 1'b0; en = 1'b0; ready = 1'b0; req = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    step(0, 8'h00, 1, 1, 2);
    // single-cycle burst then drain
    step(0, 8'b1011, 1, 1, 1);
    step(0, 8'h00, 1, 1, 6);
    // all lines held high: rotation with wrap in round-robin
    step(0, 8'hFF, 1, 1, 10);
    step(0, 8'h00, 1, 1, 10);
    // consumer stalls with one index valid
    step(0, 8'b0100, 1, 0, 1);
    step(0, 8'h00, 1, 0, 5);
    step(0, 8'h00, 1, 1, 3);
    // duplicate pulses on a pending, ungranted bit
    step(0, 8'b0001, 1, 0, 1);
    step(0, 8'b0010, 1, 0, 1);
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'b0010, 1, 0, 1);
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'b0010, 1, 0, 1);
    step(0, 8'h00, 1, 1, 5);
    // enable low: no capture, issued index held until accepted
    step(0, 8'b0100, 1, 0, 1);
    step(0, 8'h00, 1, 0, 2);
    step(0, 8'b0001, 0, 0, 3);
    step(0, 8'b0001, 0, 1, 3);
    step(0, 8'h00, 1, 1, 4);
    // reset mid-stream with pending bits and a held output
    step(0, 8'b1010, 1, 0, 2);
    step(1, 8'h00, 1, 1, 2);
    step(0, 8'h00, 1, 1, 2);
    // randomized traffic
    repeat (3000) begin
      rq = 8'($urandom) & 8'($urandom);
      step($urandom_range(99) == 0, rq, $urandom_range(9) != 0, $urandom_range(3) != 0, 1);
    end
    step(0, 8'h00, 1, 1, 20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
